// File: rtl/am2940_dma_if.sv
// Bus-side and Am2940-side signals of the DMA sequencer, grouped as one bundle.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface am2940_dma_if #(
    parameter int WIDTH = 8
);
    // Handshake: xfer_req stays high until xfer_ack is sampled high on a rising
    // edge; that edge moves one word, and xfer_ack is ignored whenever xfer_req is low.
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_ctrl;
    logic [WIDTH-1:0] cfg_addr;
    logic [WIDTH-1:0] cfg_count;
    logic [2:0]       instr;
    logic [WIDTH-1:0] dma_data;
    logic             acineg;
    logic             wcineg;
    logic             am_done;
    logic             xfer_req;
    logic             xfer_ack;
    logic             busy;
    logic [WIDTH-1:0] xfer_cnt;
    logic             finished;
    logic             err;

    modport slave (
        input  start, abort, cfg_ctrl, cfg_addr, cfg_count, am_done, xfer_ack,
        output instr, dma_data, acineg, wcineg, xfer_req, busy, xfer_cnt, finished, err
    );

    modport master (
        output start, abort, cfg_ctrl, cfg_addr, cfg_count, am_done, xfer_ack,
        input  instr, dma_data, acineg, wcineg, xfer_req, busy, xfer_cnt, finished, err
    );
endinterface

// File: rtl/am2940_dma_sequencer.sv
// Programs an Am2940 (control, address, word count) and then paces its counters,
// one count per acknowledged memory word, until the Am2940 reports DONE.
module am2940_dma_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    am2940_dma_if.slave         bus,
    output logic [2:0]          dbg_state
);
    localparam logic [2:0] I_WR_CTRL = 3'b000;
    localparam logic [2:0] I_RD_CTRL = 3'b001;
    localparam logic [2:0] I_LD_ADDR = 3'b101;
    localparam logic [2:0] I_LD_WC   = 3'b110;
    localparam logic [2:0] I_ENABLE  = 3'b111;
    localparam int         TW        = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CTRL = 3'd1,
        LD_ADDR = 3'd2,
        LD_WC   = 3'd3,
        XFER    = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] count_q;
    logic             counting;
    logic [TW-1:0]    to_cnt;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            counting     <= 1'b0;
            to_cnt       <= '0;
            bus.instr    <= I_RD_CTRL;
            bus.dma_data <= '0;
            bus.acineg   <= 1'b1;
            bus.wcineg   <= 1'b1;
            bus.xfer_req <= 1'b0;
            bus.busy     <= 1'b0;
            bus.xfer_cnt <= '0;
            bus.finished <= 1'b0;
            bus.err      <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            // Abort wins over a same-cycle ack, so no count pulse is issued.
            state        <= IDLE;
            counting     <= 1'b0;
            to_cnt       <= '0;
            bus.instr    <= I_RD_CTRL;
            bus.acineg   <= 1'b1;
            bus.wcineg   <= 1'b1;
            bus.xfer_req <= 1'b0;
            bus.busy     <= 1'b0;
            bus.finished <= 1'b0;
            bus.err      <= 1'b1;
        end else begin
            bus.finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q       <= bus.cfg_addr;
                        count_q      <= bus.cfg_count;
                        bus.err      <= 1'b0;
                        bus.xfer_cnt <= '0;
                        bus.busy     <= 1'b1;
                        bus.instr    <= I_WR_CTRL;
                        bus.dma_data <= bus.cfg_ctrl;
                        state        <= WR_CTRL;
                    end
                end
                WR_CTRL: begin
                    bus.instr    <= I_LD_ADDR;
                    bus.dma_data <= addr_q;
                    state        <= LD_ADDR;
                end
                LD_ADDR: begin
                    bus.instr    <= I_LD_WC;
                    bus.dma_data <= count_q;
                    state        <= LD_WC;
                end
                LD_WC: begin
                    bus.instr    <= I_ENABLE;
                    bus.xfer_req <= 1'b1;
                    counting     <= 1'b0;
                    to_cnt       <= '0;
                    state        <= XFER;
                end
                XFER: begin
                    if (counting) begin
                        // Count cycle: DONE only terminates when it coincides with a count.
                        counting     <= 1'b0;
                        bus.acineg   <= 1'b1;
                        bus.wcineg   <= 1'b1;
                        to_cnt       <= '0;
                        if (bus.am_done) begin
                            bus.instr    <= I_RD_CTRL;
                            bus.finished <= 1'b1;
                            state        <= FIN;
                        end else begin
                            bus.xfer_req <= 1'b1;
                        end
                    end else if (bus.xfer_ack) begin
                        counting     <= 1'b1;
                        bus.acineg   <= 1'b0;
                        bus.wcineg   <= 1'b0;
                        bus.xfer_req <= 1'b0;
                        bus.xfer_cnt <= bus.xfer_cnt + WIDTH'(1);
                        to_cnt       <= '0;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        to_cnt       <= '0;
                        bus.instr    <= I_RD_CTRL;
                        bus.xfer_req <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.err      <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.instr    <= I_RD_CTRL;
                    bus.acineg   <= 1'b1;
                    bus.wcineg   <= 1'b1;
                    bus.xfer_req <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed bench for am2940_dma_sequencer with a small Am2940 counter model.
module tb_am2940_dma_sequencer;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    am2940_dma_if #(.WIDTH(W)) bus ();

    am2940_dma_sequencer #(.WIDTH(W), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Am2940 model (mode 2): word count decrements per count, DONE while it reads 1.
    logic [W-1:0] mdl_addr = '0;
    logic [W-1:0] mdl_wc   = '0;
    always @(posedge clk) begin
        if (bus.instr == 3'b101) mdl_addr <= bus.dma_data;
        if (bus.instr == 3'b110) mdl_wc   <= bus.dma_data;
        if (bus.instr == 3'b111 && !bus.acineg) mdl_addr <= mdl_addr + 8'd1;
        if (bus.instr == 3'b111 && !bus.wcineg) mdl_wc   <= mdl_wc - 8'd1;
    end
    assign bus.am_done = (mdl_wc == 8'd1);

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start and follow the three programming cycles into the first XFER cycle.
    task automatic do_start(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] n);
        logic [10:0] e;
        bus.cfg_ctrl  = c;
        bus.cfg_addr  = a;
        bus.cfg_count = n;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        exp_q.push_back({3'b000, c});
        exp_q.push_back({3'b101, a});
        exp_q.push_back({3'b110, n});
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            check_val("prog", {21'd0, bus.instr, bus.dma_data}, {21'd0, e});
            check_val("prog_busy", bus.busy, 1);
            step();
        end
        check_val("xfer_instr", bus.instr, 3'b111);
        check_val("xfer_req", bus.xfer_req, 1);
    endtask

    initial begin
        int pulses;
        int fins;
        logic phase;
        bus.start = 0; bus.abort = 0; bus.xfer_ack = 0;
        bus.cfg_ctrl = '0; bus.cfg_addr = '0; bus.cfg_count = '0;

        // 1: reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_val("rst_instr", bus.instr, 3'b001);
        check_val("rst_acineg", bus.acineg, 1);
        check_val("rst_wcineg", bus.wcineg, 1);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_data", bus.dma_data, 0);
        check_val("rst_req", bus.xfer_req, 0);
        check_val("rst_state", dbg_state, 0);

        // 2+3: program and transfer 4 words, ack every 2nd cycle
        do_start(8'h02, 8'h01, 8'h04);
        pulses = 0; fins = 0; phase = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!bus.acineg && !bus.wcineg) pulses++;
            if (bus.finished) begin
                fins++;
                check_val("fin_cnt", bus.xfer_cnt, 4);
            end
            if (!bus.busy) break;
            bus.xfer_ack = bus.xfer_req && phase;
            phase = ~phase;
            step();
        end
        bus.xfer_ack = 1'b0;
        check_val("t3_pulses", pulses, 4);
        check_val("t3_fins", fins, 1);
        check_val("t3_cnt", bus.xfer_cnt, 4);
        check_val("t3_busy", bus.busy, 0);
        check_val("t3_err", bus.err, 0);
        check_val("t3_addr", mdl_addr, 8'h05);

        // 4: no ack -> timeout after 16 requesting cycles
        do_start(8'h02, 8'h20, 8'h08);
        fins = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.finished) fins++;
        end
        check_val("to_pre_err", bus.err, 0);
        check_val("to_pre_state", dbg_state, 4);
        step();
        if (bus.finished) fins++;
        check_val("to_err", bus.err, 1);
        check_val("to_state", dbg_state, 0);
        check_val("to_req", bus.xfer_req, 0);
        check_val("to_fins", fins, 0);

        // 5: abort with simultaneous ack
        do_start(8'h02, 8'h30, 8'h02);
        check_val("ab_err_clr", bus.err, 0);
        bus.abort = 1'b1; bus.xfer_ack = 1'b1;
        step();
        bus.abort = 1'b0; bus.xfer_ack = 1'b0;
        check_val("ab_acineg", bus.acineg, 1);
        check_val("ab_wcineg", bus.wcineg, 1);
        check_val("ab_cnt", bus.xfer_cnt, 0);
        check_val("ab_err", bus.err, 1);
        check_val("ab_state", dbg_state, 0);
        check_val("ab_req", bus.xfer_req, 0);
        do_start(8'h03, 8'h40, 8'h05);
        check_val("ab_restart_err", bus.err, 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;

        // 6: reset in LD_ADDR, then clean restart; start in XFER ignored
        bus.cfg_ctrl = 8'h02; bus.cfg_addr = 8'h11; bus.cfg_count = 8'h06;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check_val("r6_ldaddr", bus.instr, 3'b101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("r6_instr", bus.instr, 3'b001);
        check_val("r6_busy", bus.busy, 0);
        check_val("r6_state", dbg_state, 0);
        check_val("r6_data", bus.dma_data, 0);
        do_start(8'h02, 8'h05, 8'h03);
        bus.cfg_ctrl = 8'hAA; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_val("r6_ign_state", dbg_state, 4);
        check_val("r6_ign_instr", bus.instr, 3'b111);
        check_val("r6_ign_req", bus.xfer_req, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_val("r6_end_state", dbg_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
